// File: rtl/core_share_arb.sv
// -----------------------------------------------------------------------------
// core_share_arb
//
// Shares one serial-result compute core between two requesters. A round-robin
// arbiter accepts a 16-bit job, streams it to the core as four nibbles
// (MSB nibble first), waits for the core's answer, deserialises the 10-bit
// result MSB-first and returns it as a one-cycle pulse to the job's owner.
//
// Optional feature (compile-time macro CORE_WDOG_EN):
//   defined   : WAIT is bounded by TIMEOUT cycles; expiry aborts the job.
//   undefined : no latency counter, WAIT is unbounded.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   synchronous active-low reset
//   req_valid[1:0] in   per-requester job request, held until accepted
//   req_data0/1    in   16-bit jobs, [15:12] streamed first
//   req_ready[1:0] out  one-hot grant, combinational, only in IDLE
//   core_in_valid  out  nibble strobe to the core
//   core_in_data   out  nibble to the core, 0 when not sending
//   core_out_valid in   core result strobe
//   core_out_data  in   core result bit, MSB first
//   rsp_valid[1:0] out  one-cycle response pulse to the owner
//   rsp_data       out  10-bit result, 0 unless rsp_valid
//   rsp_err        out  response is an abort (timeout or truncated stream)
//   proto_err      out  sticky: core answered outside WAIT/RECV
// -----------------------------------------------------------------------------
module core_share_arb
`ifdef CORE_WDOG_EN
   #(parameter int TIMEOUT = 100)
`endif
   (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  req_valid,
   input  logic [15:0] req_data0,
   input  logic [15:0] req_data1,
   output logic [1:0]  req_ready,
   output logic        core_in_valid,
   output logic [3:0]  core_in_data,
   input  logic        core_out_valid,
   input  logic        core_out_data,
   output logic [1:0]  rsp_valid,
   output logic [9:0]  rsp_data,
   output logic        rsp_err,
   output logic        proto_err
   );

   typedef enum logic [2:0] {IDLE, SEND, WAIT, RECV, RESP} state_t;

   state_t      state, state_nxt;
   logic        last_gnt;   // 1: requester 1 was granted last
   logic        owner;
   logic        abort;
   logic        take;
   logic [1:0]  grant;
   logic [1:0]  nib_cnt;
   logic [3:0]  bit_cnt;    // RECV samples taken so far (bits 8..0)
   logic [15:0] job;
   logic [9:0]  result;

`ifdef CORE_WDOG_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] wd_cnt;
   logic             wd_expire;

   // Expiry is flagged in the WAIT cycle whose increment takes the counter
   // to TIMEOUT, so RESP lands exactly TIMEOUT cycles after WAIT entry.
   assign wd_expire = (wd_cnt == CNT_W'(TIMEOUT - 1));
`endif

   // Round-robin: on a tie the requester that was not granted last wins.
   always_comb begin
      grant = req_valid;
      if (req_valid == 2'b11)
         grant = last_gnt ? 2'b01 : 2'b10;
   end

   // Gated with rst_n so every output reads 0 while reset is held.
   assign req_ready = (state == IDLE && rst_n) ? grant : 2'b00;
   assign take      = |(req_valid & req_ready);

   always_comb begin
      state_nxt     = state;
      core_in_valid = 1'b0;
      core_in_data  = 4'd0;
      rsp_valid     = 2'b00;
      rsp_data      = 10'd0;
      rsp_err       = 1'b0;
      case (state)
         IDLE: begin
            if (take)
               state_nxt = SEND;
         end
         SEND: begin
            core_in_valid = 1'b1;
            case (nib_cnt)
               2'd0:    core_in_data = job[15:12];
               2'd1:    core_in_data = job[11:8];
               2'd2:    core_in_data = job[7:4];
               default: core_in_data = job[3:0];
            endcase
            if (nib_cnt == 2'd3)
               state_nxt = WAIT;
         end
         WAIT: begin
            if (core_out_valid)
               state_nxt = RECV;
`ifdef CORE_WDOG_EN
            else if (wd_expire)
               state_nxt = RESP;
`endif
         end
         RECV: begin
            // A dropped strobe before the 10th bit truncates the answer.
            if (!core_out_valid || bit_cnt == 4'd8)
               state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
            rsp_valid = owner ? 2'b10 : 2'b01;
            rsp_err   = abort;
            rsp_data  = abort ? 10'd0 : result;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Control state: everything that must be known-good after reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         last_gnt  <= 1'b1;
         owner     <= 1'b0;
         nib_cnt   <= 2'd0;
         bit_cnt   <= 4'd0;
         abort     <= 1'b0;
         proto_err <= 1'b0;
`ifdef CORE_WDOG_EN
         wd_cnt    <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (core_out_valid && (state == IDLE || state == SEND || state == RESP))
            proto_err <= 1'b1;
         case (state)
            IDLE: begin
               if (take) begin
                  owner    <= req_ready[1];
                  last_gnt <= req_ready[1];
                  nib_cnt  <= 2'd0;
                  abort    <= 1'b0;
               end
            end
            SEND: begin
               nib_cnt <= nib_cnt + 2'd1;
`ifdef CORE_WDOG_EN
               wd_cnt  <= '0;
`endif
            end
            WAIT: begin
               bit_cnt <= 4'd0;
`ifdef CORE_WDOG_EN
               wd_cnt  <= wd_cnt + CNT_W'(1);
               if (!core_out_valid && wd_expire)
                  abort <= 1'b1;
`endif
            end
            RECV: begin
               bit_cnt <= bit_cnt + 4'd1;
               if (!core_out_valid)
                  abort <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Datapath: job latch and result shifter, qualified by state so they need
   // no reset; outputs are masked by state anyway.
   always_ff @(posedge clk) begin
      if (state == IDLE && take)
         job <= req_ready[1] ? req_data1 : req_data0;
      if ((state == WAIT || state == RECV) && core_out_valid)
         result <= {result[8:0], core_out_data};
   end

endmodule

// File: tb/tb_core_share_arb.sv
module tb_core_share_arb;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid = 2'b00;
   logic [15:0] req_data0 = 16'd0;
   logic [15:0] req_data1 = 16'd0;
   logic        core_out_valid = 1'b0;
   logic        core_out_data = 1'b0;
   logic [1:0]  req_ready;
   logic        core_in_valid;
   logic [3:0]  core_in_data;
   logic [1:0]  rsp_valid;
   logic [9:0]  rsp_data;
   logic        rsp_err;
   logic        proto_err;

   core_share_arb dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_data0      (req_data0),
      .req_data1      (req_data1),
      .req_ready      (req_ready),
      .core_in_valid  (core_in_valid),
      .core_in_data   (core_in_data),
      .core_out_valid (core_out_valid),
      .core_out_data  (core_out_data),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .rsp_err        (rsp_err),
      .proto_err      (proto_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   bit send_win = 1'b0;   // model: the four cycles after a handshake
   bit exp_proto = 1'b0;  // model: sticky protocol error expected
   bit last_win = 1'b1;   // model: requester granted last (reset => 0 wins tie)

   typedef struct {
      bit         owner;
      logic [9:0] data;
      bit         err;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: scoreboard pop on every response, idle/window checks otherwise.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_valid_window", {31'd0, core_in_valid}, {31'd0, send_win});
         if (rsp_valid != 2'b00) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rsp_owner", {30'd0, rsp_valid}, e.owner ? 32'd2 : 32'd1);
               chk("rsp_data", {22'd0, rsp_data}, {22'd0, e.data});
               chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
               chk("rsp_cycle", cyc, e.cyc);
            end
         end else begin
            chk("quiet_rsp", {21'd0, rsp_err, rsp_data}, 32'd0);
         end
      end
   end

   task automatic wait_drain(input int budget);
      int n = 0;
      while (sb.size() != 0 && n < budget) begin
         step();
         n++;
      end
      if (sb.size() != 0) begin
         chk("rsp_timeout", sb.size(), 32'd0);
         sb.delete();
      end
   endtask

   // Present a request, check the grant, then check the four nibbles.
   task automatic do_send(input logic [1:0] vmask, input logic [15:0] d0,
                          input logic [15:0] d1, input bit stray, output bit w);
      logic [15:0] jd;
      if (vmask == 2'b11) w = ~last_win;
      else                w = vmask[1];
      last_win  = w;
      req_valid = vmask;
      req_data0 = d0;
      req_data1 = d1;
      @(negedge clk);
      chk("grant", {30'd0, req_ready}, w ? 32'd2 : 32'd1);
      step();
      req_valid = 2'b00;
      jd = w ? d1 : d0;
      send_win = 1'b1;
      for (int k = 0; k < 4; k++) begin
         core_out_valid = stray && (k == 1);
         if (stray && k == 1) exp_proto = 1'b1;
         @(negedge clk);
         chk("nibble", {28'd0, core_in_data}, {28'd0, jd[15-4*k -: 4]});
         step();
      end
      core_out_valid = 1'b0;
      send_win = 1'b0;
   endtask

   // One full job: the core answers L cycles after the last nibble with
   // nbits bits of ans (nbits < 10 models a truncated stream).
   task automatic run_job(input logic [1:0] vmask, input logic [15:0] d0,
                          input logic [15:0] d1, input int L, input logic [9:0] ans,
                          input int nbits, input bit stray);
      bit w;
      int c0;
      do_send(vmask, d0, d1, stray, w);
      repeat (L - 1) step();
      c0 = cyc;
      if (nbits >= 10) sb.push_back('{w, ans, 1'b0, c0 + 10});
      else             sb.push_back('{w, 10'd0, 1'b1, c0 + nbits + 1});
      for (int b = 0; b < nbits; b++) begin
         core_out_valid = 1'b1;
         core_out_data  = ans[9-b];
         step();
      end
      core_out_valid = 1'b0;
      core_out_data  = 1'b0;
      wait_drain(20);
      chk("proto_err", {31'd0, proto_err}, {31'd0, exp_proto});
   endtask

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (3) step();
      @(negedge clk);
      chk("reset_outputs", {11'd0, req_ready, core_in_valid, core_in_data, rsp_valid,
                            rsp_data, rsp_err, proto_err}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Ties back-to-back: grants 0, 1, 0
      for (int i = 0; i < 3; i++)
         run_job(2'b11, 16'($urandom), 16'($urandom), 2, 10'($urandom), 10, 1'b0);

      // Single job with a known answer
      run_job(2'b01, 16'h1234, 16'h0000, 3, 10'h2A5, 10, 1'b0);

      // Truncated answer, then the next job is still accepted
      run_job(2'b10, 16'h0000, 16'hA5C3, 1, 10'h3FF, 6, 1'b0);
      run_job(2'b01, 16'h0F0F, 16'h0000, 4, 10'h155, 10, 1'b0);

      // Stray core_out_valid while nibbles are being sent
      run_job(2'b10, 16'($urandom), 16'($urandom), 2, 10'($urandom), 10, 1'b1);

      // Randomized traffic
      for (int i = 0; i < 14; i++) begin
         logic [1:0] vm;
         int nb;
         vm = 2'($urandom_range(1, 3));
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 9)) : 10;
         run_job(vm, 16'($urandom), 16'($urandom), int'($urandom_range(1, 6)),
                 10'($urandom), nb, 1'b0);
      end

`ifdef CORE_WDOG_EN
      // Core never answers: abort exactly 100 cycles after WAIT entry
      begin
         bit w;
         int went;
         do_send(2'b01, 16'hBEEF, 16'h0000, 1'b0, w);
         went = cyc;
         sb.push_back('{w, 10'd0, 1'b1, went + 100});
         wait_drain(110);
         core_out_valid = 1'b1;
         step();
         core_out_valid = 1'b0;
         step();
         exp_proto = 1'b1;
         chk("late_answer_proto", {31'd0, proto_err}, 32'd1);
      end
`endif

      // Reset during RECV: leave the pointer so that a tie would go to 1
      run_job(2'b01, 16'h1111, 16'h0000, 1, 10'h0AA, 10, 1'b0);
      begin
         bit w;
         do_send(2'b01, 16'h2222, 16'h0000, 1'b0, w);
         for (int b = 0; b < 4; b++) begin
            core_out_valid = 1'b1;
            core_out_data  = 1'($urandom);
            step();
         end
         rst_n = 1'b0;
         step();
         rst_n = 1'b1;
         core_out_valid = 1'b0;
         core_out_data  = 1'b0;
         last_win  = 1'b1;
         exp_proto = 1'b0;
         @(negedge clk);
         chk("post_reset_outputs", {11'd0, req_ready, core_in_valid, core_in_data, rsp_valid,
                                    rsp_data, rsp_err, proto_err}, 32'd0);
         repeat (15) step();
      end
      run_job(2'b11, 16'h3C3C, 16'hC3C3, 2, 10'h1E1, 10, 1'b0);
      run_job(2'b11, 16'h4444, 16'h5555, 1, 10'h222, 10, 1'b0);

      repeat (3) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
